// File: rtl/prog_loader.sv
// Run controller and instruction store feeding the core's fetch path.
// Define PROG_LOADER_WATCHDOG_EN to enable the RUN-length watchdog (err[1]).
module prog_loader #(
  parameter int unsigned D           = 10,
  parameter int unsigned W           = 9,
  parameter int unsigned WDOG_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         start,
  output logic         cpu_reset,
  input  logic         cpu_done,
  input  logic [D-1:0] prog_ctr,
  output logic [W-1:0] mach_code,
  output logic [D:0]   prog_len,
  output logic [15:0]  cycle_count,
  output logic         busy,
  output logic         finished,
  output logic [1:0]   err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READY, S_RUN, S_DONE} state_e;

`ifdef PROG_LOADER_WATCHDOG_EN
  localparam bit WdogEn = 1'b1;
`else
  localparam bit WdogEn = 1'b0;
`endif

  localparam logic [D:0] PtrOne   = {{D{1'b0}}, 1'b1};
  localparam logic [D:0] LastAddr = {1'b0, {D{1'b1}}};

  state_e        state_q, state_d;
  logic [D:0]    wr_ptr_q, wr_ptr_d;
  logic [15:0]   cycle_count_q, cycle_count_d;
  logic [1:0]    err_q, err_d;
  logic          load_ready_q, cpu_reset_q, busy_q, finished_q;
  logic [W-1:0]  mem_q [0:(1<<D)-1];

  logic          beat_acc;
  logic [D-1:0]  wr_addr;
  logic [15:0]   cycle_inc;
  logic          wdog_hit;

  assign beat_acc  = load_valid & load_ready_q;
  // A beat taken outside LOAD always restarts the program at address 0.
  assign wr_addr   = (state_q == S_LOAD) ? wr_ptr_q[D-1:0] : {D{1'b0}};
  assign cycle_inc = (cycle_count_q == 16'hFFFF) ? cycle_count_q : cycle_count_q + 16'd1;
  // Fires on the edge at which the count would reach the limit.
  assign wdog_hit  = WdogEn && ((32'(cycle_count_q) + 32'd1) >= WDOG_CYCLES);

  // Next-state and datapath update decisions.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    cycle_count_d = cycle_count_q;
    err_d         = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (beat_acc) begin
          wr_ptr_d      = PtrOne;
          err_d         = 2'b00;
          cycle_count_d = 16'd0;
          state_d       = load_last ? S_READY : S_LOAD;
        end else if (start && (state_q == S_DONE)) begin
          cycle_count_d = 16'd0;
          state_d       = S_RUN;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        if (beat_acc) begin
          wr_ptr_d = wr_ptr_q + PtrOne;
          if (load_last) begin
            state_d = S_READY;
          end else if (wr_ptr_q == LastAddr) begin
            err_d[0] = 1'b1;
            state_d  = S_READY;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_READY: begin
        if (start) begin
          cycle_count_d = 16'd0;
          state_d       = S_RUN;
        end else begin
          state_d = S_READY;
        end
      end
      S_RUN: begin
        cycle_count_d = cycle_inc;
        if (cpu_done) begin
          state_d = S_DONE;
        end else if (wdog_hit) begin
          err_d[1] = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered status outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= {(D+1){1'b0}};
      cycle_count_q <= 16'd0;
      err_q         <= 2'b00;
      load_ready_q  <= 1'b1;
      cpu_reset_q   <= 1'b1;
      busy_q        <= 1'b0;
      finished_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      cycle_count_q <= cycle_count_d;
      err_q         <= err_d;
      load_ready_q  <= (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_DONE);
      cpu_reset_q   <= (state_d != S_RUN);
      busy_q        <= (state_d == S_LOAD) || (state_d == S_RUN);
      finished_q    <= (state_d == S_DONE);
    end
  end

  // Instruction RAM write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (beat_acc) begin
      mem_q[wr_addr] <= load_data;
    end
  end

  assign mach_code   = ({1'b0, prog_ctr} < wr_ptr_q) ? mem_q[prog_ctr] : {W{1'b0}};
  assign load_ready  = load_ready_q;
  assign cpu_reset   = cpu_reset_q;
  assign busy        = busy_q;
  assign finished    = finished_q;
  assign prog_len    = wr_ptr_q;
  assign cycle_count = cycle_count_q;
  assign err         = err_q;

endmodule
